// File: rtl/pc_next_if.sv
// Bus between the multicycle control FSM / datapath and the PC successor unit.
// The controller side is the master; pc_next_unit is the slave.
interface pc_next_if #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 26
);
  logic              pc_en;
  logic [2:0]        mode;
  logic [IDX_W-1:0]  instr_index;
  logic [15:0]       imm16;
  logic              branch_taken;
  logic [ADDR_W-1:0] rs_value;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] link_addr;
  logic              misalign;
  logic              ras_mismatch;
  logic              ras_empty;
  logic              ras_full;

  modport master (
    output pc_en, mode, instr_index, imm16, branch_taken, rs_value,
    input  pc, pc_plus4, link_addr, misalign, ras_mismatch, ras_empty, ras_full
  );

  modport slave (
    input  pc_en, mode, instr_index, imm16, branch_taken, rs_value,
    output pc, pc_plus4, link_addr, misalign, ras_mismatch, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_next_unit.sv
// PC register and next-PC selection (seq/branch/jump/link/jump-register) with a
// small return-address stack used to cross-check JR $ra targets.
module pc_next_unit #(
  parameter int          ADDR_W    = 32,
  parameter int          IDX_W     = 26,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_next_if.slave bus
);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] M_SEQ   = 3'd0;
  localparam logic [2:0] M_BR    = 3'd1;
  localparam logic [2:0] M_J     = 3'd2;
  localparam logic [2:0] M_JAL   = 3'd3;
  localparam logic [2:0] M_JR    = 3'd4;
  localparam logic [2:0] M_JR_RA = 3'd5;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] link_r;
  logic              misalign_r;
  logic              mismatch_r;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];

  logic [ADDR_W-1:0] p4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] target;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  inc_ptr;
  logic              is_jr;
  logic              bad_align;
  logic              do_push;
  logic              do_pop;
  logic              empty;

  assign p4     = pc_r + ADDR_W'(4);
  assign br_off = {{(ADDR_W-16){bus.imm16[15]}}, bus.imm16} << 2;

  // Upper jump bits come from pc+4 so a jump in the last slot of a region lands in the next one.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_upper
      assign jump_tgt = {p4[ADDR_W-1:IDX_W+2], bus.instr_index, 2'b00};
    end else begin : g_no_upper
      assign jump_tgt = {bus.instr_index, 2'b00};
    end
  endgenerate

  always_comb begin
    target = p4;
    case (bus.mode)
      M_BR:          if (bus.branch_taken) target = p4 + br_off;
      M_J, M_JAL:    target = jump_tgt;
      M_JR, M_JR_RA: target = bus.rs_value;
      default:       target = p4;
    endcase
  end

  assign empty     = (count == '0);
  assign is_jr     = (bus.mode == M_JR) || (bus.mode == M_JR_RA);
  assign bad_align = is_jr && (bus.rs_value[1:0] != 2'b00);
  assign do_push   = bus.pc_en && (bus.mode == M_JAL);
  assign do_pop    = bus.pc_en && (bus.mode == M_JR_RA) && !empty;
  assign top_ptr   = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
  assign inc_ptr   = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= ADDR_W'(RESET_PC);
      link_r     <= '0;
      misalign_r <= 1'b0;
      mismatch_r <= 1'b0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (bus.pc_en) begin
      pc_r       <= bad_align ? pc_r : target;
      misalign_r <= bad_align;
      mismatch_r <= (bus.mode == M_JR_RA) ? (empty || (stack[top_ptr] != bus.rs_value)) : 1'b0;
      if (do_push) begin
        link_r <= p4;
        wr_ptr <= inc_ptr;
        if (count != CNT_FULL) count <= count + CNT_W'(1);
      end else if (do_pop) begin
        wr_ptr <= top_ptr;
        count  <= count - CNT_W'(1);
      end
    end
  end

  // Stack contents need no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) stack[wr_ptr] <= p4;
  end

  assign bus.pc           = pc_r;
  assign bus.pc_plus4     = p4;
  assign bus.link_addr    = link_r;
  assign bus.misalign     = misalign_r;
  assign bus.ras_mismatch = mismatch_r;
  assign bus.ras_empty    = empty;
  assign bus.ras_full     = (count == CNT_FULL);
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: sequential, branch, jump, link, jump-register
// and return-address-stack flows, plus asynchronous reset mid-sequence.
module tb_pc_next_unit;
  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, J = 3'd2, JAL = 3'd3, JR = 3'd4, JR_RA = 3'd5;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  pc_next_if #(.ADDR_W(32), .IDX_W(26)) bus ();

  pc_next_unit #(
    .ADDR_W(32), .IDX_W(26), .RESET_PC(RST_PC), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One accepted pc_en pulse; outputs are settled at the following negedge.
  task automatic step(input logic [2:0] m, input logic [31:0] rs, input logic [25:0] idx,
                      input logic [15:0] imm, input logic tk);
    @(negedge clk);
    bus.pc_en        = 1'b1;
    bus.mode         = m;
    bus.rs_value     = rs;
    bus.instr_index  = idx;
    bus.imm16        = imm;
    bus.branch_taken = tk;
    @(negedge clk);
    bus.pc_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pc_en    = 1'b0;
      bus.mode     = JR;
      bus.rs_value = $urandom & 32'hFFFF_FFFC;
    end
  endtask

  initial begin
    bus.pc_en = 1'b0; bus.mode = SEQ; bus.rs_value = '0;
    bus.instr_index = '0; bus.imm16 = '0; bus.branch_taken = 1'b0;
    #12 rst = 1'b0;

    // 1. reset values, hold with pc_en low, sequential advance
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_p4", bus.pc_plus4, 32'h0040_0004);
    chk("rst_link", bus.link_addr, 32'h0);
    chk("rst_flags", {28'h0, bus.misalign, bus.ras_mismatch, bus.ras_empty, bus.ras_full}, 32'h2);
    idle(3);
    chk("hold_pc", bus.pc, RST_PC);
    for (int i = 0; i < 3; i++) step(SEQ, 0, 0, 0, 0);
    chk("seq3_pc", bus.pc, 32'h0040_000C);
    chk("seq3_p4", bus.pc_plus4, 32'h0040_0010);
    idle(2);
    chk("seq_hold", bus.pc, 32'h0040_000C);

    // 2. branches
    step(SEQ, 0, 0, 0, 0);
    step(BR, 0, 0, 16'hFFFC, 1);
    chk("br_back", bus.pc, 32'h0040_0004);
    step(JR, 32'h0040_0010, 0, 0, 0);
    step(BR, 0, 0, 16'hFFFC, 0);
    chk("br_not", bus.pc, 32'h0040_0014);
    step(JR, 32'hFFFF_FFF0, 0, 0, 0);
    step(BR, 0, 0, 16'h7FFF, 1);
    chk("br_wrap", bus.pc, 32'h0001_FFF0);

    // 3. jump upper bits from pc+4
    step(JR, 32'h8FFF_FFFC, 0, 0, 0);
    step(J, 0, 26'h000_0010, 0, 0);
    chk("j_region", bus.pc, 32'h9000_0040);

    // 4. JAL / JR_RA
    step(JR, 32'h0040_0020, 0, 0, 0);
    step(JAL, 0, 26'h010_0010, 0, 0);
    chk("jal_pc", bus.pc, 32'h0040_0040);
    chk("jal_link", bus.link_addr, 32'h0040_0024);
    chk("jal_nonempty", {31'h0, bus.ras_empty}, 32'h0);
    step(JR_RA, 32'h0040_0024, 0, 0, 0);
    chk("ret_pc", bus.pc, 32'h0040_0024);
    chk("ret_match", {30'h0, bus.ras_mismatch, bus.ras_empty}, 32'h1);
    step(JR_RA, 32'h0040_0100, 0, 0, 0);
    chk("ret_empty_mm", {31'h0, bus.ras_mismatch}, 32'h1);
    step(SEQ, 0, 0, 0, 0);
    chk("mm_cleared", {31'h0, bus.ras_mismatch}, 32'h0);

    // 5. misaligned JR
    step(JR, 32'h0040_0200, 0, 0, 0);
    step(JR, 32'h0040_0002, 0, 0, 0);
    chk("mis_pc", bus.pc, 32'h0040_0200);
    chk("mis_flag", {31'h0, bus.misalign}, 32'h1);
    step(SEQ, 0, 0, 0, 0);
    chk("mis_clr", {31'h0, bus.misalign}, 32'h0);
    chk("mis_seq_pc", bus.pc, 32'h0040_0204);

    // 6. RAS overflow and LIFO order
    step(JR, 32'h0000_0100, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(JAL, 0, 26'(32'h80 + 32'h40 * i), 0, 0);
      if (i == 3) chk("ras_full4", {31'h0, bus.ras_full}, 32'h1);
    end
    chk("jal5_pc", bus.pc, 32'h0000_0600);
    chk("jal5_link", bus.link_addr, 32'h0000_0504);
    chk("ras_full5", {30'h0, bus.ras_full, bus.ras_empty}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      ra = 32'h0000_0504 - 32'h100 * i;
      step(JR_RA, ra, 0, 0, 0);
      chk($sformatf("pop%0d_pc", i), bus.pc, ra);
      chk($sformatf("pop%0d_mm", i), {31'h0, bus.ras_mismatch}, 32'h0);
    end
    chk("pop_empty", {30'h0, bus.ras_full, bus.ras_empty}, 32'h1);
    step(JR_RA, 32'h0000_0104, 0, 0, 0);
    chk("oldest_gone", {31'h0, bus.ras_mismatch}, 32'h1);

    // misaligned JR_RA still pops; then async reset mid-sequence
    step(JR, 32'h0000_0100, 0, 0, 0);
    step(JAL, 0, 26'h80, 0, 0);
    step(JAL, 0, 26'hC0, 0, 0);
    step(JR_RA, 32'h0000_0999, 0, 0, 0);
    chk("mis_pop_pc", bus.pc, 32'h0000_0300);
    chk("mis_pop_flags", {28'h0, bus.misalign, bus.ras_mismatch, bus.ras_empty, bus.ras_full}, 32'hC);
    step(JR_RA, 32'h0000_0104, 0, 0, 0);
    chk("after_mis_pop", {30'h0, bus.ras_mismatch, bus.ras_empty}, 32'h1);
    step(JAL, 0, 26'h200, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc, RST_PC);
    chk("arst_p4", bus.pc_plus4, 32'h0040_0004);
    chk("arst_link", bus.link_addr, 32'h0);
    chk("arst_flags", {28'h0, bus.misalign, bus.ras_mismatch, bus.ras_empty, bus.ras_full}, 32'h2);
    #10 rst = 1'b0;
    step(SEQ, 0, 0, 0, 0);
    chk("post_rst_seq", bus.pc, 32'h0040_0004);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the fixed 4+26-bit jump-address concatenator in the multicycle MIPS datapath.
- Owns the PC register and computes the next PC for sequential, branch, jump, jump-and-link and jump-register flows.
- Keeps a small return-address stack (RAS) so the controller can check JR $ra targets against recorded call sites.
- Sits between the control FSM (which pulses pc_en in the PC-write state) and instruction fetch.

Parameters:
ADDR_W, 32, PC/address width; must satisfy ADDR_W >= IDX_W+2
IDX_W, 26, jump instruction-index width
RESET_PC, 32'h0000_0000, PC value loaded on reset (truncated to ADDR_W)
RAS_DEPTH, 4, return-address stack entries (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pc_en  input  1  one-cycle strobe from control FSM; PC and flags update only when high
mode  input  3  0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 JR_RA, 6/7 reserved
instr_index  input  IDX_W  jump field of the instruction
imm16  input  16  branch offset field
branch_taken  input  1  comparator result, used only in BR
rs_value  input  ADDR_W  register operand for JR/JR_RA
pc  output  ADDR_W  current PC (registered)
pc_plus4  output  ADDR_W  pc+4, combinational from pc, modulo 2^ADDR_W
link_addr  output  ADDR_W  registered link value written by JAL
misalign  output  1  registered; last accepted jump-register target had nonzero bits [1:0]
ras_mismatch  output  1  registered; last JR_RA popped an empty stack or a value different from rs_value
ras_empty  output  1  stack count == 0
ras_full  output  1  stack count == RAS_DEPTH

Behaviour:
- Reset (async, any time, including mid-operation): pc=RESET_PC, link_addr=0, misalign=0, ras_mismatch=0, RAS count=0, write pointer=0, so ras_empty=1 and ras_full=0. Stack contents are don't-care.
- pc_en=0: all registers hold; mode and the data inputs are ignored.
- pc_en=1: on the next rising edge, pc is loaded with target. Latency is one cycle.
- Target computation, with p4 = pc_plus4:
  - SEQ: p4.
  - BR: if branch_taken, p4 + (sign_extend(imm16) << 2), computed at ADDR_W width and wrapping modulo 2^ADDR_W; otherwise p4.
  - J and JAL: {p4[ADDR_W-1:IDX_W+2], instr_index, 2'b00}. The upper bits come from pc+4, not pc. When ADDR_W == IDX_W+2 there are no upper bits.
  - JR and JR_RA: rs_value.
  - Reserved modes 6/7: behave as SEQ; no flag is raised.
- Misalign, evaluated in JR and JR_RA only:
  - If rs_value[1:0] != 0, pc holds its old value and misalign=1.
  - Every other accepted pc_en clears misalign to 0.
- JAL:
  - link_addr <= p4.
  - Push p4 onto the RAS at the write pointer; the pointer advances modulo RAS_DEPTH.
  - count increments, saturating at RAS_DEPTH. A push when full overwrites the oldest entry and count stays RAS_DEPTH.
- JR_RA:
  - Stack non-empty: pop the top entry (pointer decrements modulo RAS_DEPTH, count decrements). ras_mismatch = (top != rs_value).
  - Stack empty: no pop, ras_mismatch=1.
  - The pop occurs even when the jump is misaligned.
- ras_mismatch is cleared by every accepted pc_en whose mode is not JR_RA.
- Push and pop cannot coincide because they come from different modes.

Test Plan:
1. Reset with RESET_PC=0x0040_0000, then three SEQ pc_en pulses -> pc = 0x0040_000C; pc_plus4 = 0x0040_0010; no pc change on cycles with pc_en=0.
2. pc=0x0040_0010, BR, imm16=0xFFFC, branch_taken=1 -> pc = 0x0040_0004. Same stimulus with branch_taken=0 -> pc = 0x0040_0014. imm16=0x7FFF taken from pc=0xFFFF_FFF0 -> wraps to 0x0001_FFF0.
3. pc=0x8FFF_FFFC, J, instr_index=0x000_0010 -> pc = 0x9000_0040; upper nibble is taken from pc+4.
4. pc=0x0040_0020, JAL, instr_index=0x0100010 -> link_addr = 0x0040_0024, ras_empty=0. Then JR_RA with rs_value=0x0040_0024 -> pc = 0x0040_0024, ras_mismatch=0, ras_empty=1. A second JR_RA -> ras_mismatch=1.
5. JR with rs_value=0x0040_0002 -> pc unchanged, misalign=1. Next SEQ -> misalign=0 and pc advances by 4.
6. RAS_DEPTH=4: five JALs -> ras_full=1 and the oldest entry is overwritten; four JR_RA pops return the last four links in LIFO order. Assert rst mid-sequence -> all outputs return to reset values immediately, without waiting for a clock edge.
